mc_datapath: RTL and testbench

Multi-cycle successor of the single-cycle processor datapath: PC, instruction register, parametrised register file, ALU and inter-stage registers (A, B, ALUOUT, MDR) driven step by step by an external control FSM. Fetch, load and store share one variable-latency memory port with a req/ack handshake managed by an internal transaction FSM. It sits between the control unit and the unified memory.

---
 rtl/mc_datapath.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle processor datapath (PC, IR, register file, ALU,
// A/B/ALUOUT/MDR) sequenced by an external control FSM, with a shared
// req/ack memory port driven by an internal two-state transaction FSM.
// Optional feature: define MC_DATAPATH_ZERO_R0_EN to hardwire register 0 to zero.
module mc_datapath #(
  parameter int RF_AW  = 5,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_sel,
  input  logic              pc_lden,
  input  logic              ab_lden,
  input  logic              rf_b_sel,
  input  logic              alu_bin_sel,
  input  logic [3:0]        alu_func,
  input  logic              alu_lden,
  input  logic              rf_wren,
  input  logic              rf_wrdata_sel,
  input  logic [1:0]        mem_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic              zero,
  output logic              ovf
);

  localparam int RF_DEPTH = 1 << RF_AW;

  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic {
    IDLE,
    REQ
  } xact_state_t;

  // Architectural and inter-stage registers
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] mdr_q, mdr_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];

  // Transaction FSM state and the request fields it holds for the whole REQ
  xact_state_t       state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;

  // Instruction fields; bits above RF_AW in the register fields are dropped
  logic [4:0]        rs_f, rd_f, rt_f;
  logic [RF_AW-1:0]  rs_idx, rd_idx, rt_idx, rb_idx;
  logic [31:0]       immed;
  logic [31:0]       rf_rd_a, rf_rd_b, rf_wr_data;
  logic [31:0]       alu_a, alu_b, alu_res;
  logic              alu_ovf;
  logic [31:0]       pc_plus4;

  assign rs_f   = ir_q[25:21];
  assign rd_f   = ir_q[20:16];
  assign rt_f   = ir_q[15:11];
  assign rs_idx = rs_f[RF_AW-1:0];
  assign rd_idx = rd_f[RF_AW-1:0];
  assign rt_idx = rt_f[RF_AW-1:0];
  assign rb_idx = rf_b_sel ? rd_idx : rt_idx;
  assign immed  = {{16{ir_q[15]}}, ir_q[15:0]};

  // Asynchronous register-file reads (old value is seen during a same-cycle write)
  always_comb begin
    rf_rd_a = rf_q[rs_idx];
    rf_rd_b = rf_q[rb_idx];
`ifdef MC_DATAPATH_ZERO_R0_EN
    if (rs_idx == '0) rf_rd_a = 32'd0;
    if (rb_idx == '0) rf_rd_b = 32'd0;
`endif
  end

  // Register-file write port: rd gets ALUOUT or MDR
  always_comb begin
    rf_d       = rf_q;
    rf_wr_data = rf_wrdata_sel ? mdr_q : aluout_q;
    if (rf_wren) begin
`ifdef MC_DATAPATH_ZERO_R0_EN
      if (rd_idx != '0) rf_d[rd_idx] = rf_wr_data;
`else
      rf_d[rd_idx] = rf_wr_data;
`endif
    end
  end

  // ALU: overflow is only meaningful for signed add/sub
  always_comb begin
    alu_a   = a_q;
    alu_b   = alu_bin_sel ? immed : b_q;
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (alu_func)
      4'd0: begin
        alu_res = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      4'd1: begin
        alu_res = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      4'd2:    alu_res = alu_a & alu_b;
      4'd3:    alu_res = alu_a | alu_b;
      4'd4:    alu_res = ~alu_a;
      4'd5:    alu_res = {alu_a[31], alu_a[31:1]};
      4'd6:    alu_res = {1'b0, alu_a[31:1]};
      4'd7:    alu_res = {alu_a[30:0], 1'b0};
      4'd8:    alu_res = {alu_a[30:0], alu_a[31]};
      4'd9:    alu_res = {alu_a[0], alu_a[31:1]};
      default: alu_res = 32'd0;
    endcase
  end

  // Next values of the control-driven registers (PC, A, B, ALUOUT, flags)
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (pc_lden) pc_d = pc_sel ? (pc_plus4 + {immed[29:0], 2'b00}) : pc_plus4;
    if (ab_lden) begin
      a_d = rf_rd_a;
      b_d = rf_rd_b;
    end
    if (alu_lden) begin
      aluout_d = alu_res;
      zero_d   = (alu_res == 32'd0);
      ovf_d    = alu_ovf;
    end
  end

  // Transaction FSM: latch request in IDLE, wait for ack in REQ, then pulse done
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: begin
        if (mem_op != 2'b00) begin
          state_d = REQ;
          op_d    = mem_op;
          addr_d  = (mem_op == OP_FETCH) ? pc_q[MEM_AW+1:2] : aluout_q[MEM_AW+1:2];
          we_d    = (mem_op == OP_STORE);
          wdata_d = b_q;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
          we_d    = 1'b0;
          if (op_q == OP_FETCH) ir_d = mem_rdata;
          else if (op_q == OP_LOAD) mdr_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register for all datapath and transaction flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= 32'd0;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
      mdr_q    <= 32'd0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= 32'd0;
      state_q  <= IDLE;
      op_q     <= 2'b00;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      rf_q     <= rf_d;
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_busy  = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_done  = done_q;
  assign instr     = ir_q;
  assign pc        = pc_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed testbench for mc_datapath: builds register values through the
// datapath itself and checks PC, ALU flags and the memory handshake.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_sel = 0, pc_lden = 0, ab_lden = 0, rf_b_sel = 0;
  logic        alu_bin_sel = 0, alu_lden = 0, rf_wren = 0, rf_wrdata_sel = 0;
  logic [3:0]  alu_func = 0;
  logic [1:0]  mem_op = 0;
  logic        mem_req, mem_we, mem_busy, mem_done, zero, ovf;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, instr, pc;
  logic [31:0] mem_rdata = 0;
  logic        mem_ack = 0;

  int checks = 0;
  int passed = 0;

  mc_datapath #(.RF_AW(5), .MEM_AW(10)) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .pc_lden(pc_lden),
    .ab_lden(ab_lden), .rf_b_sel(rf_b_sel), .alu_bin_sel(alu_bin_sel),
    .alu_func(alu_func), .alu_lden(alu_lden), .rf_wren(rf_wren),
    .rf_wrdata_sel(rf_wrdata_sel), .mem_op(mem_op), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_done(mem_done), .instr(instr), .pc(pc), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    mem_ack = 1'b1;
    mem_rdata = w;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic ab(input logic bsel);
    ab_lden = 1'b1;
    rf_b_sel = bsel;
    step();
    ab_lden = 1'b0;
    rf_b_sel = 1'b0;
  endtask

  task automatic alu(input logic [3:0] f, input logic bin);
    alu_func = f;
    alu_bin_sel = bin;
    alu_lden = 1'b1;
    step();
    alu_lden = 1'b0;
    alu_bin_sel = 1'b0;
  endtask

  task automatic wr(input logic sel);
    rf_wren = 1'b1;
    rf_wrdata_sel = sel;
    step();
    rf_wren = 1'b0;
    rf_wrdata_sel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (pc !== 32'd0) $display("[TB] FAIL reset_pc got %h want 0", pc); else passed++;
    checks++; if (instr !== 32'd0) $display("[TB] FAIL reset_ir got %h want 0", instr); else passed++;
    checks++; if ({zero, ovf} !== 2'b00) $display("[TB] FAIL reset_flags got %b want 00", {zero, ovf}); else passed++;
    checks++; if ({mem_req, mem_we, mem_busy, mem_done} !== 4'b0000)
      $display("[TB] FAIL reset_mem got %b want 0000", {mem_req, mem_we, mem_busy, mem_done}); else passed++;
    checks++; if (mem_wdata !== 32'd0) $display("[TB] FAIL reset_wdata got %h want 0", mem_wdata); else passed++;
  endtask

  task automatic test_fetch();
    int pulses;
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    checks++; if ({mem_req, mem_busy, mem_we} !== 3'b110) $display("[TB] FAIL fetch_req got %b want 110", {mem_req, mem_busy, mem_we}); else passed++;
    checks++; if (mem_addr !== 10'd0) $display("[TB] FAIL fetch_addr got %h want 0", mem_addr); else passed++;
    step();
    step();
    checks++; if (instr !== 32'd0) $display("[TB] FAIL fetch_ir_early got %h want 0", instr); else passed++;
    mem_ack = 1'b1;
    mem_rdata = 32'h0420_1234;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++; if (instr !== 32'h0420_1234) $display("[TB] FAIL fetch_ir got %h want 04201234", instr); else passed++;
    checks++; if ({mem_req, mem_busy} !== 2'b00) $display("[TB] FAIL fetch_idle got %b want 00", {mem_req, mem_busy}); else passed++;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_done === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses != 1) $display("[TB] FAIL fetch_done_pulses got %0d want 1", pulses); else passed++;
  endtask

  task automatic test_pc();
    pc_lden = 1'b1;
    pc_sel = 1'b0;
    repeat (4) step();
    pc_lden = 1'b0;
    checks++; if (pc !== 32'h10) $display("[TB] FAIL pc_inc got %h want 10", pc); else passed++;
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    checks++; if (mem_addr !== 10'd4) $display("[TB] FAIL pc_fetch_addr got %h want 4", mem_addr); else passed++;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_FFFF;
    step();
    mem_ack = 1'b0;
    pc_sel = 1'b1;
    pc_lden = 1'b1;
    step();
    pc_lden = 1'b0;
    checks++; if (pc !== 32'h10) $display("[TB] FAIL pc_branch_neg got %h want 10", pc); else passed++;
    fetch(32'h0000_0002);
    pc_lden = 1'b1;
    step();
    pc_lden = 1'b0;
    pc_sel = 1'b0;
    checks++; if (pc !== 32'h1C) $display("[TB] FAIL pc_branch_pos got %h want 1c", pc); else passed++;
  endtask

  task automatic test_alu();
    // r1 = 0 + (-1)
    fetch(32'h0001_FFFF);
    ab(1'b0);
    alu(4'd0, 1'b1);
    checks++; if ({zero, ovf} !== 2'b00) $display("[TB] FAIL alu_add_imm got %b want 00", {zero, ovf}); else passed++;
    wr(1'b0);
    // r1 = r1 >> 1 = 0x7FFFFFFF
    fetch(32'h0021_0000);
    ab(1'b0);
    alu(4'd6, 1'b0);
    wr(1'b0);
    // r2 = 1
    fetch(32'h0002_0001);
    ab(1'b0);
    alu(4'd0, 1'b1);
    wr(1'b0);
    // r1 + r2 overflows
    fetch(32'h0022_0000);
    ab(1'b1);
    alu(4'd0, 1'b0);
    checks++; if ({zero, ovf} !== 2'b01) $display("[TB] FAIL alu_add_ovf got %b want 01", {zero, ovf}); else passed++;
    alu(4'd2, 1'b0);
    checks++; if ({zero, ovf} !== 2'b00) $display("[TB] FAIL alu_and_flags got %b want 00", {zero, ovf}); else passed++;
    alu(4'd12, 1'b0);
    checks++; if ({zero, ovf} !== 2'b10) $display("[TB] FAIL alu_func12 got %b want 10", {zero, ovf}); else passed++;
    // r1 - r1 = 0
    fetch(32'h0021_0000);
    ab(1'b1);
    alu(4'd1, 1'b0);
    checks++; if ({zero, ovf} !== 2'b10) $display("[TB] FAIL alu_sub_zero got %b want 10", {zero, ovf}); else passed++;
  endtask

  task automatic test_load();
    fetch(32'h0003_0008);
    ab(1'b0);
    alu(4'd0, 1'b1);
    mem_op = 2'b10;
    step();
    mem_op = 2'b00;
    checks++; if ({mem_req, mem_we} !== 2'b10) $display("[TB] FAIL load_req got %b want 10", {mem_req, mem_we}); else passed++;
    checks++; if (mem_addr !== 10'd2) $display("[TB] FAIL load_addr got %h want 2", mem_addr); else passed++;
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++; if (mem_done !== 1'b1) $display("[TB] FAIL load_done got %b want 1", mem_done); else passed++;
    wr(1'b1);
  endtask

  task automatic test_store();
    ab(1'b1);
    mem_op = 2'b11;
    step();
    mem_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 10'd2 || mem_wdata !== 32'hDEAD_BEEF)
        $display("[TB] FAIL store_hold%0d got req/we=%b addr=%h wdata=%h want 11 2 deadbeef",
                 i, {mem_req, mem_we}, mem_addr, mem_wdata);
      else passed++;
      if (i == 4) break;
      if (i == 1) mem_op = 2'b01;
      if (i == 2) mem_op = 2'b10;
      step();
      mem_op = 2'b00;
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++; if ({mem_done, mem_req, mem_we} !== 3'b100) $display("[TB] FAIL store_end got %b want 100", {mem_done, mem_req, mem_we}); else passed++;
    checks++; if (instr !== 32'h0003_0008) $display("[TB] FAIL store_ir got %h want 00030008", instr); else passed++;
    step();
    checks++; if ({mem_done, mem_req} !== 2'b00) $display("[TB] FAIL store_ignored_op got %b want 00", {mem_done, mem_req}); else passed++;
  endtask

  task automatic test_r0();
    fetch(32'h0000_0000);
    wr(1'b1);
    ab(1'b0);
    alu(4'd3, 1'b1);
`ifdef MC_DATAPATH_ZERO_R0_EN
    checks++; if (zero !== 1'b1) $display("[TB] FAIL r0_hardwired got zero=%b want 1", zero); else passed++;
`else
    checks++; if (zero !== 1'b0) $display("[TB] FAIL r0_plain got zero=%b want 0", zero); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 1'b0;
    checks++; if ({mem_done, mem_req} !== 2'b10 || instr !== 32'hA5A5_0001)
      $display("[TB] FAIL b2b_first got done/req=%b ir=%h want 10 a5a50001", {mem_done, mem_req}, instr); else passed++;
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    checks++; if ({mem_done, mem_req} !== 2'b01) $display("[TB] FAIL b2b_restart got %b want 01", {mem_done, mem_req}); else passed++;
    mem_ack = 1'b1;
    mem_rdata = 32'h5A5A_0002;
    step();
    mem_ack = 1'b0;
    checks++; if (instr !== 32'h5A5A_0002) $display("[TB] FAIL b2b_second got %h want 5a5a0002", instr); else passed++;
    step();
    checks++; if ({mem_done, mem_req} !== 2'b00) $display("[TB] FAIL b2b_idle got %b want 00", {mem_done, mem_req}); else passed++;
  endtask

  task automatic test_reset_mid();
    mem_op = 2'b01;
    step();
    mem_op = 2'b00;
    step();
    checks++; if (mem_req !== 1'b1) $display("[TB] FAIL rst_mid_pre got %b want 1", mem_req); else passed++;
    reset = 1'b1;
    #1;
    checks++; if ({mem_req, mem_busy} !== 2'b00) $display("[TB] FAIL rst_mid_async got %b want 00", {mem_req, mem_busy}); else passed++;
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    checks++; if (instr !== 32'd0) $display("[TB] FAIL rst_mid_ir got %h want 0", instr); else passed++;
    checks++; if ({mem_done, mem_req} !== 2'b00) $display("[TB] FAIL rst_mid_done got %b want 00", {mem_done, mem_req}); else passed++;
    step();
    checks++; if ({mem_done, zero, ovf} !== 3'b000 || pc !== 32'd0)
      $display("[TB] FAIL rst_mid_state got done/zero/ovf=%b pc=%h want 000 0", {mem_done, zero, ovf}, pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_pc();
    test_alu();
    test_load();
    test_store();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
